vector_load_seq: RTL and testbench

VECTOR_LOAD_SEQ -- requirements
Module: vector_load_seq

---
 rtl/vector_load_seq.sv | 208 ++++++++++++++++++++
 tb/tb_vector_load_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_load_seq.sv
// vector_load_seq: sequences a unit-stride vector load, one bus word read
// and one vector-register write per element (byte, half or word elements).
// Latency: 2 + 2*vl cycles from accepted start to o_done with zero-wait acks.
// Backpressure: REQ holds o_dbus_cyc/o_dbus_adr until i_dbus_ack; i_start is ignored while busy.
//
// Ports: i_clk/i_rst (sync, active-high); i_start/i_base_addr/i_width/i_vl/i_vd launch a load;
// o_busy/o_done/o_err report status; o_dbus_* / i_dbus_* form the read bus;
// o_mem_data/o_shift_offset/o_vreg_shift/o_width feed the external aligner, whose result
// i_aligned is written through o_vreg_we/o_vreg_addr/o_vreg_wdata/o_vreg_be.
// Optional macro VECTOR_LOAD_TIMEOUT_EN: abort a REQ with err=1 after 255 cycles without ack.
module vector_load_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_base_addr,
    input  logic [2:0]  i_width,
    input  logic [5:0]  i_vl,
    input  logic [4:0]  i_vd,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_dbus_adr,
    output logic        o_dbus_cyc,
    output logic [3:0]  o_dbus_sel,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdt,
    output logic [31:0] o_mem_data,
    output logic [1:0]  o_shift_offset,
    output logic [1:0]  o_vreg_shift,
    output logic [2:0]  o_width,
    input  logic [31:0] i_aligned,
    output logic        o_vreg_we,
    output logic [7:0]  o_vreg_addr,
    output logic [31:0] o_vreg_wdata,
    output logic [3:0]  o_vreg_be
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  width_q, width_d;
    logic [5:0]  vl_q, vl_d;
    logic [4:0]  vd_q, vd_d;
    logic [5:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic [31:0] mem_data_q, mem_data_d;

`ifdef VECTOR_LOAD_TIMEOUT_EN
    logic [7:0]  to_cnt_q, to_cnt_d;
`endif

    logic [1:0]  sz_shift;     // log2 of element size in bytes
    logic [31:0] elem_off;     // byte offset of the current element from base
    logic [31:0] elem_addr;
    logic [7:0]  byte_cnt;     // vl * E, at most 63*4 = 252
    logic        misaligned;
    logic [1:0]  lane;
    logic [3:0]  be_val;
    logic [5:0]  idx_inc;

    // Element geometry is derived from the latched fields so it stays
    // stable across REQ and WRITE of each element.
    always_comb begin
        sz_shift = 2'd0;
        if (width_q == 3'b101) begin
            sz_shift = 2'd1;
        end else if (width_q == 3'b110) begin
            sz_shift = 2'd2;
        end
        elem_off   = {26'd0, idx_q} << sz_shift;
        elem_addr  = base_q + elem_off;
        byte_cnt   = {2'b00, vl_q} << sz_shift;
        misaligned = ((sz_shift == 2'd1) && base_q[0]) ||
                     ((sz_shift == 2'd2) && (base_q[1:0] != 2'b00));
        idx_inc    = idx_q + 6'd1;

        // Lane is the element's slot within its destination word: i mod (4/E).
        lane   = 2'd0;
        be_val = 4'hF;
        case (sz_shift)
            2'd0: begin
                lane   = idx_q[1:0];
                be_val = 4'b0001 << lane;
            end
            2'd1: begin
                lane   = {1'b0, idx_q[0]};
                be_val = idx_q[0] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane   = 2'd0;
                be_val = 4'hF;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        width_d    = width_q;
        vl_d       = vl_q;
        vd_d       = vd_q;
        idx_d      = idx_q;
        err_d      = err_q;
        mem_data_d = mem_data_q;
`ifdef VECTOR_LOAD_TIMEOUT_EN
        // Held at zero outside REQ so every entry to REQ starts a fresh count.
        to_cnt_d   = (state_q == S_REQ) ? to_cnt_q : 8'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    base_d  = i_base_addr;
                    width_d = i_width;
                    vl_d    = i_vl;
                    vd_d    = i_vd;
                    idx_d   = 6'd0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (misaligned || (byte_cnt > 8'd32)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (vl_q == 6'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_dbus_ack) begin
                    mem_data_d = i_dbus_rdt;
                    state_d    = S_WRITE;
`ifdef VECTOR_LOAD_TIMEOUT_EN
                end else if (to_cnt_q == 8'd254) begin
                    // This edge is the 255th REQ cycle without ack.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
`endif
                end
            end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc < vl_q) ? S_REQ : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            base_q     <= 32'd0;
            width_q    <= 3'd0;
            vl_q       <= 6'd0;
            vd_q       <= 5'd0;
            idx_q      <= 6'd0;
            err_q      <= 1'b0;
            mem_data_q <= 32'd0;
`ifdef VECTOR_LOAD_TIMEOUT_EN
            to_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            width_q    <= width_d;
            vl_q       <= vl_d;
            vd_q       <= vd_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            mem_data_q <= mem_data_d;
`ifdef VECTOR_LOAD_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign o_busy         = (state_q == S_CHECK) || (state_q == S_REQ) || (state_q == S_WRITE);
    assign o_done         = (state_q == S_DONE);
    assign o_err          = (state_q == S_DONE) && err_q;
    assign o_dbus_cyc     = (state_q == S_REQ);
    assign o_dbus_sel     = (state_q == S_REQ) ? 4'hF : 4'h0;
    assign o_dbus_adr     = {elem_addr[31:2], 2'b00};
    assign o_mem_data     = mem_data_q;
    assign o_shift_offset = elem_addr[1:0];
    assign o_vreg_shift   = lane;
    assign o_width        = width_q;
    assign o_vreg_we      = (state_q == S_WRITE);
    assign o_vreg_addr    = {vd_q, elem_off[4:2]};
    assign o_vreg_wdata   = i_aligned;
    assign o_vreg_be      = (state_q == S_WRITE) ? be_val : 4'h0;

endmodule

// File: tb/tb_vector_load_seq.sv
// Bench for vector_load_seq: directed loads checked cycle by cycle against an
// element-list model, plus literal expectations for the worked examples.
module tb_vector_load_seq;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_dbus_ack;
    logic [31:0] i_base_addr, i_dbus_rdt, i_aligned;
    logic [2:0]  i_width;
    logic [5:0]  i_vl;
    logic [4:0]  i_vd;
    logic        o_busy, o_done, o_err, o_dbus_cyc, o_vreg_we;
    logic [31:0] o_dbus_adr, o_mem_data, o_vreg_wdata;
    logic [3:0]  o_dbus_sel, o_vreg_be;
    logic [1:0]  o_shift_offset, o_vreg_shift;
    logic [2:0]  o_width;
    logic [7:0]  o_vreg_addr;

    always #5 clk = ~clk;

    // Stand-in aligner: a fixed transform so the write data proves which word was latched.
    assign i_aligned = o_mem_data ^ 32'h5A5A_5A5A;

    vector_load_seq dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_width(i_width), .i_vl(i_vl), .i_vd(i_vd), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_dbus_adr(o_dbus_adr), .o_dbus_cyc(o_dbus_cyc), .o_dbus_sel(o_dbus_sel),
        .i_dbus_ack(i_dbus_ack), .i_dbus_rdt(i_dbus_rdt), .o_mem_data(o_mem_data),
        .o_shift_offset(o_shift_offset), .o_vreg_shift(o_vreg_shift), .o_width(o_width),
        .i_aligned(i_aligned), .o_vreg_we(o_vreg_we), .o_vreg_addr(o_vreg_addr),
        .o_vreg_wdata(o_vreg_wdata), .o_vreg_be(o_vreg_be)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- bus responder ----------------
    int ack_dly [64];
    int ack_cnt  = 0;
    int wait_cnt = 0;
    bit stray    = 1'b0;

    always @(negedge clk) begin
        if (!o_busy) ack_cnt = 0;
        if (o_dbus_cyc) begin
            if (wait_cnt >= ack_dly[ack_cnt]) begin
                i_dbus_ack = 1'b1;
                i_dbus_rdt = 32'hA5C3_0000 + 32'(ack_cnt);
                if (ack_cnt < 63) ack_cnt++;
                wait_cnt = 0;
            end else begin
                i_dbus_ack = stray;
                wait_cnt++;
            end
        end else begin
            i_dbus_ack = stray;
            wait_cnt   = 0;
        end
    end

    task automatic clr_dly();
        for (int i = 0; i < 64; i++) ack_dly[i] = 0;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_base;
    logic [2:0]  m_width;
    int  m_vl, m_vd, m_e, m_cycle, m_done_cycle, m_widx, m_run, m_n_cyc, m_n_wr, done_seen;
    bit  m_active = 1'b0;
    bit  m_err_exp;
    logic [31:0] log_adr  [8];
    logic [1:0]  log_off  [8];
    logic [3:0]  log_be   [8];
    logic [7:0]  log_vadr [8];

    function automatic int esize(input logic [2:0] w);
        if (w == 3'b101) return 2;
        if (w == 3'b110) return 4;
        return 1;
    endfunction

    always @(negedge clk) begin
        logic [31:0] a;
        logic [3:0]  be;
        int lane, word;
        if (m_active) begin
            m_cycle++;
            chk("busy", 32'(o_busy), 32'(m_cycle < m_done_cycle));
            chk("done", 32'(o_done), 32'(m_cycle == m_done_cycle));
            a    = m_base + 32'(m_widx * m_e);
            lane = m_widx % (4 / m_e);
            word = (m_widx * m_e) / 4;
            be   = (m_e == 1) ? 4'(1 << lane) : (m_e == 2) ? 4'(3 << (2 * lane)) : 4'hF;
            if (o_dbus_cyc) begin
                if (m_widx >= m_n_cyc) chk("unexpected_cyc", 32'd1, 32'd0);
                else begin
                    chk("dbus_adr", o_dbus_adr, a & 32'hFFFF_FFFC);
                    chk("dbus_sel", 32'(o_dbus_sel), 32'hF);
                    chk("cyc_shift_offset", 32'(o_shift_offset), a & 32'd3);
                    chk("cyc_vreg_shift", 32'(o_vreg_shift), 32'(lane));
                    chk("cyc_width", 32'(o_width), 32'(m_width));
                end
                m_run++;
            end
            if (o_vreg_we) begin
                if (m_widx >= m_n_wr) chk("unexpected_we", 32'd1, 32'd0);
                else begin
                    chk("vreg_addr", 32'(o_vreg_addr), 32'(m_vd * 8 + (word % 8)));
                    chk("vreg_be", 32'(o_vreg_be), 32'(be));
                    chk("vreg_wdata", o_vreg_wdata, (32'hA5C3_0000 + 32'(m_widx)) ^ 32'h5A5A_5A5A);
                    chk("we_shift_offset", 32'(o_shift_offset), a & 32'd3);
                    chk("we_vreg_shift", 32'(o_vreg_shift), 32'(lane));
                    chk("cyc_run_len", 32'(m_run), 32'(1 + ack_dly[m_widx]));
                    if (m_widx < 8) begin
                        log_adr[m_widx]  = o_dbus_adr;
                        log_off[m_widx]  = o_shift_offset;
                        log_be[m_widx]   = o_vreg_be;
                        log_vadr[m_widx] = o_vreg_addr;
                    end
                end
                m_widx++;
                m_run = 0;
            end
            if (o_done) begin
                chk("err", 32'(o_err), 32'(m_err_exp));
                chk("write_count", 32'(m_widx), 32'(m_n_wr));
                done_seen = m_cycle;
                m_active  = 1'b0;
            end
        end
    end

    task automatic run_load(input logic [31:0] base, input logic [2:0] w, input int vl,
                            input int vd, input bit tmo);
        int e, sum;
        e = esize(w);
        sum = 0;
        m_base = base; m_width = w; m_vl = vl; m_vd = vd; m_e = e;
        m_widx = 0; m_run = 0; m_cycle = 0; done_seen = -1;
        if ((int'(base[1:0]) % e) != 0 || vl * e > 32) begin
            m_err_exp = 1'b1; m_n_cyc = 0; m_n_wr = 0; m_done_cycle = 2;
        end else if (vl == 0) begin
            m_err_exp = 1'b0; m_n_cyc = 0; m_n_wr = 0; m_done_cycle = 2;
        end else if (tmo) begin
            m_err_exp = 1'b1; m_n_cyc = 1; m_n_wr = 0; m_done_cycle = 2 + 255;
        end else begin
            for (int i = 0; i < vl; i++) sum += ack_dly[i];
            m_err_exp = 1'b0; m_n_cyc = vl; m_n_wr = vl; m_done_cycle = 2 + 2 * vl + sum;
        end
        @(negedge clk);
        i_start = 1'b1; i_base_addr = base; i_width = w; i_vl = vl[5:0]; i_vd = vd[4:0];
        @(posedge clk);
        #1 i_start = 1'b0;
        m_active = 1'b1;
        for (int k = 0; k < m_done_cycle + 20 && m_active; k++) @(posedge clk);
        if (m_active) begin
            chk("load_completion_timeout", 32'd1, 32'd0);
            m_active = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        clr_dly();
        i_rst = 1'b1; i_start = 1'b0; i_base_addr = 32'd0; i_width = 3'd0;
        i_vl = 6'd0; i_vd = 5'd0; i_dbus_ack = 1'b0; i_dbus_rdt = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_cyc", 32'(o_dbus_cyc), 32'd0);
        chk("rst_we", 32'(o_vreg_we), 32'd0);
        chk("rst_be", 32'(o_vreg_be), 32'd0);
        chk("rst_adr", o_dbus_adr, 32'd0);
        chk("rst_mem_data", o_mem_data, 32'd0);
        chk("rst_width", 32'(o_width), 32'd0);
        chk("rst_vreg_addr", 32'(o_vreg_addr), 32'd0);
        @(negedge clk) i_rst = 1'b0;

        // Byte load from an odd base
        run_load(32'h0000_1001, 3'b000, 3, 3, 1'b0);
        chk("byte_done_cycle", 32'(done_seen), 32'd8);
        for (int i = 0; i < 3; i++) chk("byte_lit_adr", log_adr[i], 32'h0000_1000);
        chk("byte_lit_off0", 32'(log_off[0]), 32'd1);
        chk("byte_lit_off2", 32'(log_off[2]), 32'd3);
        chk("byte_lit_be0", 32'(log_be[0]), 32'h1);
        chk("byte_lit_be1", 32'(log_be[1]), 32'h2);
        chk("byte_lit_be2", 32'(log_be[2]), 32'h4);

        // Half load with acks also driven outside REQ (must be ignored)
        stray = 1'b1;
        run_load(32'h0000_2002, 3'b101, 4, 7, 1'b0);
        stray = 1'b0;
        chk("half_lit_adr0", log_adr[0], 32'h0000_2000);
        chk("half_lit_adr1", log_adr[1], 32'h0000_2004);
        chk("half_lit_adr2", log_adr[2], 32'h0000_2004);
        chk("half_lit_adr3", log_adr[3], 32'h0000_2008);
        chk("half_lit_vadr1", 32'(log_vadr[1]), 32'h38);
        chk("half_lit_vadr2", 32'(log_vadr[2]), 32'h39);
        chk("half_lit_be0", 32'(log_be[0]), 32'h3);
        chk("half_lit_be1", 32'(log_be[1]), 32'hC);

        // Misaligned word and vl=0: two-cycle completion, no bus cycle
        run_load(32'h0000_3001, 3'b110, 1, 0, 1'b0);
        chk("misalign_done_cycle", 32'(done_seen), 32'd2);
        run_load(32'h0000_4000, 3'b110, 0, 0, 1'b0);
        chk("vl0_done_cycle", 32'(done_seen), 32'd2);

        // Capacity boundary: 8 words fits, 9 words aborts
        run_load(32'h0000_5000, 3'b110, 8, 31, 1'b0);
        chk("word8_lit_vadr7", 32'(log_vadr[7]), 32'hFF);
        run_load(32'h0000_5000, 3'b110, 9, 31, 1'b0);

        // Delayed ack on element 1
        ack_dly[1] = 5;
        run_load(32'h0000_6000, 3'b000, 3, 2, 1'b0);
        chk("delay_done_cycle", 32'(done_seen), 32'd13);
        clr_dly();

        // Undefined width code behaves as bytes
        run_load(32'h0000_7003, 3'b011, 2, 4, 1'b0);
        chk("odd_width_lit_adr1", log_adr[1], 32'h0000_7004);

        // Reset during REQ of element 2, then a clean load
        ack_dly[2] = 10;
        @(negedge clk);
        i_start = 1'b1; i_base_addr = 32'h0000_8000; i_width = 3'b000; i_vl = 6'd4; i_vd = 5'd1;
        @(posedge clk);
        #1 i_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_dbus_cyc && ack_cnt == 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_mid_reach_req2", 32'(found), 32'd1);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_cyc", 32'(o_dbus_cyc), 32'd0);
        chk("rst_mid_done", 32'(o_done), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_mem_data", o_mem_data, 32'd0);
        @(negedge clk) i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_no_done", 32'(o_done), 32'd0);
        end
        clr_dly();
        run_load(32'h0000_8000, 3'b000, 4, 1, 1'b0);
        chk("after_rst_done_cycle", 32'(done_seen), 32'd10);

`ifdef VECTOR_LOAD_TIMEOUT_EN
        ack_dly[0] = 100000;
        run_load(32'h0000_9000, 3'b110, 1, 2, 1'b1);
        chk("timeout_done_cycle", 32'(done_seen), 32'd257);
        clr_dly();
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
